// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//
// Purpose: shares one APB bus between two independent command sources.
// Requests are arbitrated round-robin in IDLE, the winner's command is run
// through the APB SETUP/ACCESS phases, and read data, error status and a
// one-cycle done pulse are returned to the winner. A wait-state timeout
// aborts an ACCESS phase that a slave never completes.
//
// Ports:
//   PCLK, PRESETn        clock (rising edge) / synchronous active-low reset
//   reqN, wrN            requester N request (held until doneN) and direction
//   addrN, wdataN        requester N address and write data
//   rdataN, doneN, errN  requester N read data, completion pulse, error flag
//   PSEL1, PSEL2         slave selects, decoded from PADDR[SEL_BIT]
//   PENABLE, PWRITE      APB enable and direction
//   PADDR, PWDATA        APB address and write data
//   PRDATA, PREADY,      APB read data, ready and slave error from the
//   PSLVERR              selected slave
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_BIT = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // The counter holds the number of wait cycles already spent in ACCESS, so
  // the abort fires on the ACCESS cycle where it equals TIMEOUT-1: that is
  // the TIMEOUT-th ACCESS cycle with PREADY low.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t              state_q,   state_d;
  logic                ptr_q,     ptr_d;      // requester that wins a tie
  logic                gnt_q,     gnt_d;      // requester owning the bus
  logic                psel1_q,   psel1_d;
  logic                psel2_q,   psel2_d;
  logic                penable_q, penable_d;
  logic                pwrite_q,  pwrite_d;
  logic [ADDR_W-1:0]   paddr_q,   paddr_d;
  logic [DATA_W-1:0]   pwdata_q,  pwdata_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                done0_q,   done0_d;
  logic                done1_q,   done1_d;
  logic                err0_q,    err0_d;
  logic                err1_q,    err1_d;
  logic [DATA_W-1:0]   rdata0_q,  rdata0_d;
  logic [DATA_W-1:0]   rdata1_q,  rdata1_d;

  // Winner selection and command mux for the IDLE grant.
  logic              win;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  always_comb begin
    // A lone requester wins outright; a tie goes to the pointer holder.
    win       = (req0 && req1) ? ptr_q : req1;
    win_wr    = win ? wr1    : wr0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;
  end

  // Completion of the ACCESS phase, either by PREADY or by timeout.
  logic              fin;
  logic              fin_err;
  logic [DATA_W-1:0] fin_rdata;
  logic              timeout_hit;

  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_rdata   = '0;
    if (state_q == S_ACCESS) begin
      if (PREADY) begin
        fin       = 1'b1;
        fin_err   = PSLVERR;
        fin_rdata = pwrite_q ? '0 : PRDATA;
      end else if (timeout_hit) begin
        fin       = 1'b1;
        fin_err   = 1'b1;
        fin_rdata = '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    cnt_d     = cnt_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = err0_q;
    err1_d    = err1_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d     = win;
          ptr_d     = ~win;
          pwrite_d  = win_wr;
          paddr_d   = win_addr;
          pwdata_d  = win_wdata;
          psel1_d   = ~win_addr[SEL_BIT];
          psel2_d   =  win_addr[SEL_BIT];
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (fin) begin
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          state_d   = S_DONE;
          if (gnt_q) begin
            done1_d  = 1'b1;
            err1_d   = fin_err;
            rdata1_d = fin_rdata;
          end else begin
            done0_d  = 1'b1;
            err0_d   = fin_err;
            rdata0_d = fin_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      cnt_q     <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      cnt_q     <= cnt_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign PSEL1   = psel1_q;
  assign PSEL2   = psel2_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// Directed scenarios followed by randomized rounds. The expected winner,
// bus phases, latency and returned data are derived from a transaction-level
// model: a tie pointer, the per-requester last result, and the slave
// behaviour chosen for each transaction.
// ---------------------------------------------------------------------------
module tb_apb_master_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SEL = 4;
  localparam int TO  = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [DW-1:0] rdata0, rdata1;
  logic          done0, done1, err0, err1;
  logic          PSEL1, PSEL2, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  apb_master_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .SEL_BIT(SEL),
    .TIMEOUT(TO)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .req0   (req0),
    .req1   (req1),
    .wr0    (wr0),
    .wr1    (wr1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rdata0 (rdata0),
    .rdata1 (rdata1),
    .done0  (done0),
    .done1  (done1),
    .err0   (err0),
    .err1   (err1),
    .PSEL1  (PSEL1),
    .PSEL2  (PSEL2),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit            ptr_m;
  logic [DW-1:0] last_rd [2];
  bit            last_er [2];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic new_cmd(input bit r);
    if (r) begin
      req1 = 1'b1; wr1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
    end else begin
      req0 = 1'b1; wr0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
    end
  endtask

  task automatic check_held();
    chk32("rdata0_hold", rdata0, last_rd[0]);
    chk32("rdata1_hold", rdata1, last_rd[1]);
    chk1("err0_hold", err0, last_er[0]);
    chk1("err1_hold", err1, last_er[1]);
  endtask

  // Runs one transaction starting from an IDLE cycle where requests are
  // already stable. Ends in the IDLE cycle following DONE.
  task automatic run_txn(input int waits, input bit stuck, input bit slverr,
                         input logic [DW-1:0] prdata, input bit renew);
    bit            w;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] exp_rd;
    bit            exp_er;
    int            n_acc;

    w        = (req0 && req1) ? ptr_m : bit'(req1);
    exp_wr   = w ? wr1 : wr0;
    exp_addr = w ? addr1 : addr0;
    exp_wd   = w ? wdata1 : wdata0;
    exp_rd   = (stuck || exp_wr) ? '0 : prdata;
    exp_er   = stuck ? 1'b1 : slverr;
    n_acc    = stuck ? TO : waits + 1;

    // SETUP
    tick();
    chk1("setup_psel1", PSEL1, ~exp_addr[SEL]);
    chk1("setup_psel2", PSEL2, exp_addr[SEL]);
    chk1("setup_penable", PENABLE, 1'b0);
    chk32("setup_paddr", PADDR, exp_addr);
    chk1("setup_pwrite", PWRITE, exp_wr);
    chk32("setup_pwdata", PWDATA, exp_wd);
    chk1("setup_done", done0 | done1, 1'b0);
    // Slave response is ignored outside ACCESS: drive noise here.
    PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;

    for (int k = 0; k < n_acc; k++) begin
      tick();
      chk1("access_psel1", PSEL1, ~exp_addr[SEL]);
      chk1("access_psel2", PSEL2, exp_addr[SEL]);
      chk1("access_penable", PENABLE, 1'b1);
      chk32("access_paddr", PADDR, exp_addr);
      chk1("access_done", done0 | done1, 1'b0);
      if (!stuck && k == waits) begin
        PREADY = 1'b1; PSLVERR = slverr; PRDATA = prdata;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
    end

    // DONE
    tick();
    last_rd[w] = exp_rd;
    last_er[w] = exp_er;
    ptr_m      = !w;
    chk1("done_win", w ? done1 : done0, 1'b1);
    chk1("done_other", w ? done0 : done1, 1'b0);
    chk1("done_psel", PSEL1 | PSEL2, 1'b0);
    chk1("done_penable", PENABLE, 1'b0);
    chk32("done_paddr_hold", PADDR, exp_addr);
    check_held();
    $display("txn: req%0d %s addr=%h waits=%0d stuck=%0d rdata=%h err=%0d",
             w, exp_wr ? "WR" : "RD", exp_addr, waits, stuck, exp_rd, exp_er);
    PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
    if (renew) new_cmd(w);
    else if (w) req1 = 1'b0;
    else req0 = 1'b0;

    // Following IDLE
    tick();
    PREADY = 1'b0;
    chk1("idle_psel", PSEL1 | PSEL2, 1'b0);
    chk1("idle_penable", PENABLE, 1'b0);
    chk1("idle_done", done0 | done1, 1'b0);
  endtask

  initial begin
    PRESETn = 1'b0;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    ptr_m = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0; last_er[0] = 1'b0; last_er[1] = 1'b0;

    // Reset values
    tick(); tick();
    chk1("rst_psel1", PSEL1, 1'b0);
    chk1("rst_psel2", PSEL2, 1'b0);
    chk1("rst_penable", PENABLE, 1'b0);
    chk1("rst_pwrite", PWRITE, 1'b0);
    chk32("rst_paddr", PADDR, '0);
    chk32("rst_pwdata", PWDATA, '0);
    chk1("rst_done0", done0, 1'b0);
    chk1("rst_done1", done1, 1'b0);
    check_held();
    PRESETn = 1'b1;
    tick();
    chk1("idle_no_req", PSEL1 | PSEL2 | PENABLE, 1'b0);

    // Single write from requester 0 to PSEL2 with zero wait states
    req0 = 1; wr0 = 1; addr0 = 32'h12; wdata0 = 32'hDEADBEEF;
    run_txn(0, 0, 0, 32'h0, 0);

    // Read from requester 1 on PSEL1 with 3 wait states
    req1 = 1; wr1 = 0; addr1 = 32'h05; wdata1 = $urandom;
    run_txn(3, 0, 0, 32'hDABBCAFE, 0);
    chk32("read_rdata1", rdata1, 32'hDABBCAFE);

    // Both requesters hold req: grants alternate
    new_cmd(0); new_cmd(1);
    for (int i = 0; i < 4; i++) run_txn(0, 0, 1'($urandom), $urandom, 1);
    for (int i = 0; i < 3 && (req0 || req1); i++) run_txn(0, 0, 0, $urandom, 0);

    // Hung slave: timeout abort
    req0 = 1; wr0 = 0; addr0 = $urandom; wdata0 = $urandom;
    run_txn(0, 1, 0, $urandom, 0);
    chk1("timeout_err0", err0, 1'b1);
    chk32("timeout_rdata0", rdata0, '0);

    // Slave error on a write, then a clean transaction
    req1 = 1; wr1 = 1; addr1 = $urandom; wdata1 = $urandom;
    run_txn(1, 0, 1, $urandom, 1);
    chk1("slverr_err1", err1, 1'b1);
    run_txn(0, 0, 0, $urandom, 0);
    chk1("clean_err1", err1, 1'b0);

    // Reset during ACCESS: no done, pointer back to requester 0
    req0 = 1; wr0 = 0; addr0 = $urandom;
    run_txn(0, 0, 0, $urandom, 0);     // grant to 0 moves pointer to 1
    new_cmd(0); new_cmd(1);
    tick();                             // SETUP
    PREADY = 1'b0;
    tick();                             // ACCESS
    chk1("pre_rst_penable", PENABLE, 1'b1);
    PRESETn = 1'b0;
    tick();
    chk1("rst_mid_psel", PSEL1 | PSEL2, 1'b0);
    chk1("rst_mid_penable", PENABLE, 1'b0);
    chk1("rst_mid_done", done0 | done1, 1'b0);
    PRESETn = 1'b1;
    ptr_m = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0; last_er[0] = 1'b0; last_er[1] = 1'b0;
    run_txn(0, 0, 0, $urandom, 0);     // model expects requester 0
    for (int i = 0; i < 2 && (req0 || req1); i++) run_txn(0, 0, 0, $urandom, 0);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      if (!req0 && 1'($urandom)) new_cmd(0);
      if (!req1 && 1'($urandom)) new_cmd(1);
      if (!req0 && !req1) begin
        tick();
        chk1("rand_idle", PSEL1 | PSEL2 | PENABLE | done0 | done1, 1'b0);
        new_cmd(1'($urandom));
      end
      run_txn(int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
              1'($urandom), $urandom, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
